pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a small return stack.
// Each cycle it takes one action: interrupt entry, return, call, jump,
// increment or hold. A one-cycle BOOT state follows reset. A one-cycle
// IRQ_ENTRY state marks interrupt entry.
//
// Output qualification: pc_out is a fetch address only while pc_valid=1.
// There is no ready input. The consumer samples pc_out on every rising edge
// at which pc_valid=1. irq_ack is meaningful in those cycles only.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    STACK_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  next,
    input  logic                  stall,
    input  logic                  jump,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  reti,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  irq,
    input  logic [ADDR_WIDTH-1:0] irq_vector,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  pc_valid,
    output logic                  irq_ack,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_IRQ_ENTRY = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_IRQ  = 3'd1,
        ACT_RETI = 3'd2,
        ACT_RET  = 3'd3,
        ACT_CALL = 3'd4,
        ACT_JUMP = 3'd5,
        ACT_NEXT = 3'd6
    } act_t;

    state_t                state_q, state_d;
    act_t                  act;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [SP_W-1:0]       sp_q, sp_d;
    logic                  irq_en_q, irq_en_d;
    logic                  err_q, err_d;
    logic                  empty_q, full_q;
    logic                  push_en;
    logic [ADDR_WIDTH-1:0] push_data;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      top_idx;
    logic [SP_W-1:0]       sp_dec;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    // Wrapping increment (0xFFFF rolls over to 0x0000 silently).
    // Push slot is sp and the top entry is sp-1.
    assign pc_inc    = pc_q + PC_ONE;
    assign sp_dec    = sp_q - SP_ONE;
    assign push_idx  = sp_q[IDX_W-1:0];
    assign top_idx   = sp_dec[IDX_W-1:0];
    assign stack_top = stack_mem[top_idx];

    // Priority decode of the single action taken this cycle. Only RUN without stall acts.
    // A pending irq against a full stack falls through to the lower-priority requests.
    always_comb begin
        act = ACT_HOLD;
        if (state_q == ST_RUN && !stall) begin
            if (irq && irq_en_q && !full_q) act = ACT_IRQ;
            else if (reti)                  act = ACT_RETI;
            else if (ret)                   act = ACT_RET;
            else if (call)                  act = ACT_CALL;
            else if (jump)                  act = ACT_JUMP;
            else if (next)                  act = ACT_NEXT;
            else                            act = ACT_HOLD;
        end
    end

    // FSM state register; reset forces BOOT immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_BOOT;
        else      state_q <= state_d;
    end

    // FSM next state: BOOT and IRQ_ENTRY each last one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:      state_d = ST_RUN;
            ST_RUN:       state_d = (act == ACT_IRQ) ? ST_IRQ_ENTRY : ST_RUN;
            ST_IRQ_ENTRY: state_d = ST_RUN;
            default:      state_d = ST_BOOT;
        endcase
    end

    // Datapath next values for pc, stack pointer, interrupt enable and error.
    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        irq_en_d  = irq_en_q;
        err_d     = err_q;
        push_en   = 1'b0;
        push_data = pc_q;
        case (act)
            ACT_IRQ: begin
                push_en   = 1'b1;
                push_data = pc_q;
                sp_d      = sp_q + SP_ONE;
                pc_d      = irq_vector;
                irq_en_d  = 1'b0;
            end
            ACT_RETI, ACT_RET: begin
                if (act == ACT_RETI) irq_en_d = 1'b1;
                if (empty_q) begin
                    err_d = 1'b1;
                end else begin
                    pc_d = stack_top;
                    sp_d = sp_dec;
                end
            end
            ACT_CALL: begin
                if (full_q) begin
                    err_d = 1'b1;
                end else begin
                    push_en   = 1'b1;
                    push_data = pc_inc;
                    sp_d      = sp_q + SP_ONE;
                    pc_d      = target;
                end
            end
            ACT_JUMP: pc_d = target;
            ACT_NEXT: pc_d = pc_inc;
            default:  pc_d = pc_q;
        endcase
    end

    // Datapath registers. The occupancy flags update on the same edge as pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_VECTOR;
            sp_q     <= '0;
            irq_en_q <= 1'b1;
            err_q    <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            irq_en_q <= irq_en_d;
            err_q    <= err_d;
            empty_q  <= (sp_d == '0);
            full_q   <= (sp_d == SP_FULL);
        end
    end

    // Return-stack storage. Entries above sp are dead, so reset only clears sp.
    always_ff @(posedge clk) begin
        if (push_en) stack_mem[push_idx] <= push_data;
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        pc_out      = pc_q;
        pc_valid    = (state_q != ST_BOOT);
        irq_ack     = (state_q == ST_IRQ_ENTRY);
        stack_empty = empty_q;
        stack_full  = full_q;
        err         = err_q;
        state_dbg   = state_q;
    end

endmodule
